ra_inject_arbiter: RTL and testbench

Packet-level arbiter that shares the single router injection port of a remote-access tile between two flit sources: the processor-side packetizer (requests and write-backs) and the cache-side packetizer (replies to remote requests). It grants whole packets, holds a grant from head flit to tail flit, checks per-VC full status before accepting, and drives a registered flit onto the router input.

---
 rtl/ra_inject_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ra_inject_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_inject_arbiter.sv
// ra_inject_arbiter
// Packet-level arbiter that shares one router injection port between the
// processor-side packetizer (P) and the cache-side packetizer (C). Whole
// packets are granted: a head flit locks the port to its source until the
// matching tail. A source is eligible only if the VC of its flit is not full.
// The accepted flit is registered onto out_flit one cycle after acceptance.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   p_flit/p_valid      processor-side flit and valid
//   p_ready             processor flit accepted this cycle (combinational)
//   c_flit/c_valid      cache-side flit and valid
//   c_ready             cache flit accepted this cycle (combinational)
//   out_flit/out_valid  registered flit to the router, valid one cycle/flit
//   out_full            per-VC router buffer full (one entry of slack)
//   grant_src           source of current out_flit: 0 processor, 1 cache
//   busy                packet lock held
//   proto_err           sticky protocol-error flag
//
// Build option: define RA_INJ_ARB_CACHE_PRIO_EN for fixed cache-over-processor
// priority in IDLE; otherwise packets are granted round-robin.
// Flit layout MSB..LSB: flow, type, vc, data.
module ra_inject_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned VC_BITS    = 1,
    parameter int unsigned ID_BITS    = 4,
    parameter int unsigned EXTRA      = 2,
    parameter int unsigned TYPE_BITS  = 2,
    localparam int unsigned FLOW_BITS    = 2 * ID_BITS + EXTRA,
    localparam int unsigned VC_PER_PORTS = 1 << VC_BITS,
    localparam int unsigned FLIT_WIDTH   = FLOW_BITS + TYPE_BITS + VC_BITS + DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [FLIT_WIDTH-1:0]   p_flit,
    input  logic                    p_valid,
    output logic                    p_ready,
    input  logic [FLIT_WIDTH-1:0]   c_flit,
    input  logic                    c_valid,
    output logic                    c_ready,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic                    out_valid,
    input  logic [VC_PER_PORTS-1:0] out_full,
    output logic                    grant_src,
    output logic                    busy,
    output logic                    proto_err
);

    localparam logic [1:0] TypeBody   = 2'b00;
    localparam logic [1:0] TypeHead   = 2'b01;
    localparam logic [1:0] TypeTail   = 2'b10;
    localparam logic [1:0] TypeSingle = 2'b11;

    typedef enum logic [1:0] {StIdle, StLockP, StLockC} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic                  r_out_valid;
    logic                  r_grant_src;
    logic                  r_proto_err;

    logic [VC_BITS-1:0]    w_p_vc;
    logic [VC_BITS-1:0]    w_c_vc;
    logic                  w_p_elig;
    logic                  w_c_elig;
    logic                  w_pick_c;
    logic                  w_p_ready;
    logic                  w_c_ready;
    logic                  w_acc;
    logic [FLIT_WIDTH-1:0] w_acc_flit;
    logic [1:0]            w_acc_type;
    logic                  w_err_hit;

    assign w_p_vc   = p_flit[DATA_WIDTH +: VC_BITS];
    assign w_c_vc   = c_flit[DATA_WIDTH +: VC_BITS];
    assign w_p_elig = p_valid && !out_full[w_p_vc];
    assign w_c_elig = c_valid && !out_full[w_c_vc];

`ifdef RA_INJ_ARB_CACHE_PRIO_EN
    // Replies always drain first so remote requests can never deadlock on them.
    assign w_pick_c = w_c_elig;
`else
    logic r_last_grant;  // 1: cache won the last IDLE grant

    // Cache wins a tie only if the processor had the previous grant.
    assign w_pick_c = w_c_elig && (!w_p_elig || !r_last_grant);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == StIdle && w_acc) begin
            r_last_grant <= w_c_ready;
        end
    end
`endif

    always_comb begin
        w_p_ready  = 1'b0;
        w_c_ready  = 1'b0;
        w_state_d  = r_state;
        w_err_hit  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_pick_c) begin
                    w_c_ready = 1'b1;
                end else if (w_p_elig) begin
                    w_p_ready = 1'b1;
                end
            end
            StLockP: w_p_ready = w_p_elig;
            StLockC: w_c_ready = w_c_elig;
            default: ;
        endcase

        if (reset) begin
            w_p_ready = 1'b0;
            w_c_ready = 1'b0;
        end

        w_acc      = w_p_ready || w_c_ready;
        w_acc_flit = w_c_ready ? c_flit : p_flit;
        w_acc_type = w_acc_flit[DATA_WIDTH + VC_BITS +: 2];

        if (w_acc) begin
            if (r_state == StIdle) begin
                if (w_acc_type == TypeHead) begin
                    w_state_d = w_c_ready ? StLockC : StLockP;
                end
                // Orphan body/tail is still forwarded, only flagged.
                w_err_hit = (w_acc_type == TypeBody) || (w_acc_type == TypeTail);
            end else begin
                if (w_acc_type == TypeTail || w_acc_type == TypeSingle) begin
                    w_state_d = StIdle;
                end
                w_err_hit = (w_acc_type == TypeHead);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
            r_grant_src <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_out_valid <= w_acc;
            if (w_acc) begin
                r_out_flit  <= w_acc_flit;
                r_grant_src <= w_c_ready;
            end
            if (w_err_hit) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign p_ready   = w_p_ready;
    assign c_ready   = w_c_ready;
    assign out_flit  = r_out_flit;
    assign out_valid = r_out_valid;
    assign grant_src = r_grant_src;
    assign busy      = (r_state != StIdle);
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ra_inject_arbiter.sv
// Directed self-checking bench for ra_inject_arbiter (default parameters).
module tb_ra_inject_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 10 + 2 + 1 + DW;

    localparam logic [1:0] TBody   = 2'b00;
    localparam logic [1:0] THead   = 2'b01;
    localparam logic [1:0] TTail   = 2'b10;
    localparam logic [1:0] TSingle = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] p_flit = '0;
    logic          p_valid = 1'b0;
    logic          p_ready;
    logic [FW-1:0] c_flit = '0;
    logic          c_valid = 1'b0;
    logic          c_ready;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic [1:0]    out_full = 2'b00;
    logic          grant_src;
    logic          busy;
    logic          proto_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ra_inject_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .p_flit    (p_flit),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .c_flit    (c_flit),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_full  (out_full),
        .grant_src (grant_src),
        .busy      (busy),
        .proto_err (proto_err)
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] typ, input logic vc,
                                         input logic [31:0] data);
        logic [9:0] flow;
        flow = 10'h2A5;
        return {flow, typ, vc, data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; #1 later the combinational readies are checked.
    task automatic drive_point();
        @(negedge clock);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [FW-1:0] pf;
        logic [FW-1:0] cf;

        // Reset state; ready must stay low while reset is high.
        p_valid = 1'b1;
        p_flit  = mk(TSingle, 1'b0, 32'h0000_00A1);
        #1;
        chk("rst_p_ready", {63'd0, p_ready}, 64'd0);
        @(posedge clock);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_flit", {19'd0, out_flit}, 64'd0);
        chk("rst_grant_src", {63'd0, grant_src}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
        p_valid = 1'b0;

        // Single-flit packets from both sources: strict P,C,P,C alternation.
        drive_point();
        reset   = 1'b0;
        pf      = mk(TSingle, 1'b0, 32'h0000_00A1);
        cf      = mk(TSingle, 1'b1, 32'h0000_00C1);
        p_flit  = pf;
        c_flit  = cf;
        p_valid = 1'b1;
        c_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) drive_point();
            else #1;
            chk("rr_p_ready", {63'd0, p_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_c_ready", {63'd0, c_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            after_edge();
            chk("rr_out_valid", {63'd0, out_valid}, 64'd1);
            chk("rr_grant_src", {63'd0, grant_src}, (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("rr_out_flit", {19'd0, out_flit}, (i % 2 == 1) ? {19'd0, cf} : {19'd0, pf});
        end
        drive_point();
        p_valid = 1'b0;
        c_valid = 1'b0;
        after_edge();
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // P sends head/body/body/tail while C waits; C is held off until the tail.
        drive_point();
        c_flit  = mk(TSingle, 1'b0, 32'h0000_00C2);
        c_valid = 1'b1;
        p_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) drive_point();
            pf     = mk((k == 0) ? THead : ((k == 3) ? TTail : TBody), 1'b0, 32'h0000_0B00 + k);
            p_flit = pf;
            #1;
            chk("pkt_p_ready", {63'd0, p_ready}, 64'd1);
            chk("pkt_c_ready", {63'd0, c_ready}, 64'd0);
            after_edge();
            chk("pkt_out_flit", {19'd0, out_flit}, {19'd0, pf});
            chk("pkt_busy", {63'd0, busy}, (k < 3) ? 64'd1 : 64'd0);
        end
        drive_point();
        p_valid = 1'b0;
        #1;
        chk("pkt_c_after_tail", {63'd0, c_ready}, 64'd1);
        after_edge();
        chk("pkt_c_grant_src", {63'd0, grant_src}, 64'd1);
        chk("pkt_c_flit", {19'd0, out_flit}, {19'd0, mk(TSingle, 1'b0, 32'h0000_00C2)});
        chk("pkt_no_err", {63'd0, proto_err}, 64'd0);

        // VC0 full: P on VC0 blocked, C on VC1 proceeds, P resumes on release.
        drive_point();
        out_full = 2'b01;
        pf       = mk(TSingle, 1'b0, 32'h0000_00A3);
        cf       = mk(TSingle, 1'b1, 32'h0000_00C3);
        p_flit   = pf;
        c_flit   = cf;
        p_valid  = 1'b1;
        c_valid  = 1'b1;
        #1;
        chk("full_p_ready", {63'd0, p_ready}, 64'd0);
        chk("full_c_ready", {63'd0, c_ready}, 64'd1);
        after_edge();
        chk("full_grant_c", {63'd0, grant_src}, 64'd1);
        drive_point();
        c_valid = 1'b0;
        #1;
        chk("full_p_stall", {63'd0, p_ready}, 64'd0);
        after_edge();
        chk("full_stall_ov", {63'd0, out_valid}, 64'd0);
        drive_point();
        out_full = 2'b00;
        #1;
        chk("rel_p_ready", {63'd0, p_ready}, 64'd1);
        after_edge();
        chk("rel_grant_p", {63'd0, grant_src}, 64'd0);
        chk("rel_out_flit", {19'd0, out_flit}, {19'd0, pf});

        // Orphan body from P in IDLE: forwarded, proto_err sticks.
        drive_point();
        pf     = mk(TBody, 1'b1, 32'h0000_0BAD);
        p_flit = pf;
        #1;
        chk("orph_p_ready", {63'd0, p_ready}, 64'd1);
        after_edge();
        chk("orph_out_flit", {19'd0, out_flit}, {19'd0, pf});
        chk("orph_proto_err", {63'd0, proto_err}, 64'd1);
        chk("orph_busy", {63'd0, busy}, 64'd0);
        drive_point();
        p_valid = 1'b0;
        after_edge();
        after_edge();
        chk("orph_err_sticky", {63'd0, proto_err}, 64'd1);

        // Reset during LOCK_C: lock dropped, P wins the first tie afterwards.
        drive_point();
        c_flit  = mk(THead, 1'b0, 32'h0000_0C10);
        c_valid = 1'b1;
        after_edge();
        chk("lockc_busy", {63'd0, busy}, 64'd1);
        drive_point();
        pf      = mk(TSingle, 1'b0, 32'h0000_00A5);
        p_flit  = pf;
        p_valid = 1'b1;
        c_flit  = mk(TBody, 1'b0, 32'h0000_0C11);
        #1;
        chk("lockc_p_held", {63'd0, p_ready}, 64'd0);
        chk("lockc_c_ready", {63'd0, c_ready}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_c_ready", {63'd0, c_ready}, 64'd0);
        chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_proto_err", {63'd0, proto_err}, 64'd0);
        after_edge();
        drive_point();
        reset  = 1'b0;
        c_flit = mk(THead, 1'b0, 32'h0000_0C20);
        #1;
        chk("post_p_ready", {63'd0, p_ready}, 64'd1);
        chk("post_c_ready", {63'd0, c_ready}, 64'd0);
        after_edge();
        chk("post_grant_p", {63'd0, grant_src}, 64'd0);
        chk("post_out_flit", {19'd0, out_flit}, {19'd0, pf});
        chk("post_busy", {63'd0, busy}, 64'd0);
        drive_point();
        p_valid = 1'b0;
        #1;
        chk("post_c_head", {63'd0, c_ready}, 64'd1);
        after_edge();
        chk("post_c_busy", {63'd0, busy}, 64'd1);
        drive_point();
        c_flit = mk(TTail, 1'b0, 32'h0000_0C21);
        after_edge();
        chk("post_c_tail_busy", {63'd0, busy}, 64'd0);
        chk("post_c_no_err", {63'd0, proto_err}, 64'd0);
        drive_point();
        c_valid = 1'b0;

`ifdef RA_INJ_ARB_CACHE_PRIO_EN
        // Fixed priority: cache always wins, processor starved while C streams.
        drive_point();
        p_flit  = mk(TSingle, 1'b0, 32'h0000_00A7);
        c_flit  = mk(TSingle, 1'b1, 32'h0000_00C7);
        p_valid = 1'b1;
        c_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j != 0) drive_point();
            else #1;
            chk("prio_c_ready", {63'd0, c_ready}, 64'd1);
            chk("prio_p_ready", {63'd0, p_ready}, 64'd0);
            after_edge();
            chk("prio_grant_c", {63'd0, grant_src}, 64'd1);
        end
        drive_point();
        c_valid = 1'b0;
        #1;
        chk("prio_p_after", {63'd0, p_ready}, 64'd1);
        after_edge();
        chk("prio_grant_p", {63'd0, grant_src}, 64'd0);
        drive_point();
        p_valid = 1'b0;
`endif

        after_edge();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
